// File: rtl/inst_loader_pkg.sv
// Shared widths and loader FSM encodings for the boot-time instruction loader.
// The state codes are plain 3-bit constants so legacy code can reuse the same values.
package inst_loader_pkg;

    localparam int PC_LENGTH   = 32;
    localparam int INST_LENGTH = 32;

    localparam logic [2:0] LOADER_HDR0 = 3'd0;
    localparam logic [2:0] LOADER_HDR1 = 3'd1;
    localparam logic [2:0] LOADER_DATA = 3'd2;
    localparam logic [2:0] LOADER_DONE = 3'd3;
    localparam logic [2:0] LOADER_ERR  = 3'd4;

endpackage

// File: rtl/inst_loader.sv
// Receives a count-prefixed, big-endian byte stream and writes packed 32-bit words
// into the instruction memory, holding the CPU in reset until the image is complete.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = PC_LENGTH,
    parameter int                    DATA_WIDTH = INST_LENGTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            inData,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic                  start,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  holdCpu,
    output logic                  done,
    output logic                  err
);

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    logic [2:0]            state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [23:0]           pack_q, pack_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  accept;
    logic [15:0]           hdr_n;

    assign inReady = (state_q == LOADER_HDR0) || (state_q == LOADER_HDR1) ||
                     (state_q == LOADER_DATA);
    assign accept  = inValid && inReady;
    assign hdr_n   = {cnt_q[15:8], inData};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        pack_d     = pack_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        case (state_q)
            LOADER_HDR0: begin
                if (accept) begin
                    cnt_d[15:8] = inData;
                    state_d     = LOADER_HDR1;
                end
            end
            LOADER_HDR1: begin
                if (accept) begin
                    cnt_d      = hdr_n;
                    byte_idx_d = 2'd0;
                    word_idx_d = 16'd0;
                    if (hdr_n == 16'd0) begin
                        state_d = LOADER_DONE;
                    end else if ({1'b0, hdr_n} > MAX_N) begin
                        state_d = LOADER_ERR;
                    end else begin
                        state_d = LOADER_DATA;
                    end
                end
            end
            LOADER_DATA: begin
                if (accept) begin
                    pack_d     = {pack_q[15:0], inData};
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Fourth byte completes the word; the write issues without stalling the stream.
                    if (byte_idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = DATA_WIDTH'({pack_q, inData});
                        waddr_d = BASE_ADDR + ADDR_WIDTH'({word_idx_q, 2'b00});
                        if (word_idx_q == cnt_q - 16'd1) begin
                            state_d = LOADER_DONE;
                        end else begin
                            word_idx_d = word_idx_q + 16'd1;
                        end
                    end
                end
            end
            LOADER_DONE, LOADER_ERR: begin
                if (start) begin
                    state_d = LOADER_HDR0;
                end
            end
            default: begin
                state_d = LOADER_HDR0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= LOADER_HDR0;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            pack_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= BASE_ADDR;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            pack_q     <= pack_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign done  = (state_q == LOADER_DONE);
    assign err   = (state_q == LOADER_ERR);
    // The final write is still in flight during the first DONE cycle.
    assign holdCpu = (state_q != LOADER_DONE) || we_q;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: two instances (base 0 and base 0x100) share one stream.
module tb_inst_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  inData = 8'h00;
    logic        inValid = 1'b0;
    logic        start = 1'b0;

    logic        inReady0, we0, holdCpu0, done0, err0;
    logic [31:0] waddr0, wdata0;
    logic        inReady1, we1, holdCpu1, done1, err1;
    logic [31:0] waddr1, wdata1;

    wr_t         q0[$];
    wr_t         q1[$];
    logic [31:0] img[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    inst_loader dut0 (
        .clk(clk), .rst(rst), .inData(inData), .inValid(inValid), .inReady(inReady0),
        .start(start), .we(we0), .waddr(waddr0), .wdata(wdata0), .holdCpu(holdCpu0),
        .done(done0), .err(err0)
    );

    inst_loader #(.BASE_ADDR(32'h0000_0100)) dut1 (
        .clk(clk), .rst(rst), .inData(inData), .inValid(inValid), .inReady(inReady1),
        .start(start), .we(we1), .waddr(waddr1), .wdata(wdata1), .holdCpu(holdCpu1),
        .done(done1), .err(err1)
    );

    // Write monitors: every we pulse must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e0;
        wr_t e1;
        if (we0 === 1'b1) begin
            n_cmp++;
            if (q0.size() == 0) begin
                n_bad++;
                $display("FAIL dut0_write: unexpected we addr=%h data=%h", waddr0, wdata0);
            end else begin
                e0 = q0.pop_front();
                if (waddr0 !== e0.addr || wdata0 !== e0.data) begin
                    n_bad++;
                    $display("FAIL dut0_write: got %h/%h want %h/%h", waddr0, wdata0, e0.addr, e0.data);
                end
            end
        end
        if (we1 === 1'b1) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_bad++;
                $display("FAIL dut1_write: unexpected we addr=%h data=%h", waddr1, wdata1);
            end else begin
                e1 = q1.pop_front();
                if (waddr1 !== e1.addr || wdata1 !== e1.data) begin
                    n_bad++;
                    $display("FAIL dut1_write: got %h/%h want %h/%h", waddr1, wdata1, e1.addr, e1.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int waited;
        bit rdy;
        waited = 0;
        rdy = 1'b0;
        if (gap) begin
            inValid = 1'b0;
            @(posedge clk); #1;
            n_cmp++;
            if (inReady0 !== 1'b1) begin
                n_bad++;
                $display("FAIL gap_ready: inReady=%b want 1", inReady0);
            end
        end
        inData = b;
        inValid = 1'b1;
        do begin
            @(negedge clk);
            rdy = inReady0;
            @(posedge clk); #1;
            waited++;
        end while (!rdy && waited < 20);
        inValid = 1'b0;
        if (!rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: byte %h not accepted, want accepted", b);
        end
        $display("byte %h accepted", b);
    endtask

    task automatic send_image(input bit gap);
        logic [15:0] n;
        n = 16'(img.size());
        for (int i = 0; i < img.size(); i++) begin
            q0.push_back('{addr: 32'(4 * i), data: img[i]});
            q1.push_back('{addr: 32'h100 + 32'(4 * i), data: img[i]});
        end
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        foreach (img[i]) begin
            send_byte(img[i][31:24], gap);
            send_byte(img[i][23:16], gap);
            send_byte(img[i][15:8], gap);
            send_byte(img[i][7:0], gap);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (done0 !== 1'b0 || err0 !== 1'b0 || inReady0 !== 1'b1 || holdCpu0 !== 1'b1) begin
            n_bad++;
            $display("FAIL start_rearm: done=%b err=%b rdy=%b hold=%b want 0 0 1 1",
                     done0, err0, inReady0, holdCpu0);
        end
        $display("start pulse");
    endtask

    task automatic check_last_word(input string name);
        n_cmp++;
        if (we0 !== 1'b1 || done0 !== 1'b1 || holdCpu0 !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_last: we=%b done=%b hold=%b want 1 1 1", name, we0, done0, holdCpu0);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (we0 !== 1'b0 || done0 !== 1'b1 || holdCpu0 !== 1'b0 || holdCpu1 !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_release: we=%b done=%b hold0=%b hold1=%b want 0 1 0 0",
                     name, we0, done0, holdCpu0, holdCpu1);
        end
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL %s_missing: pending writes %0d/%0d want 0/0", name, q0.size(), q1.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (inReady0 !== 1'b1 || holdCpu0 !== 1'b1 || we0 !== 1'b0 || done0 !== 1'b0 ||
            err0 !== 1'b0 || waddr0 !== 32'h0 || wdata0 !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_dut0: rdy=%b hold=%b we=%b done=%b err=%b addr=%h data=%h",
                     inReady0, holdCpu0, we0, done0, err0, waddr0, wdata0);
        end
        n_cmp++;
        if (waddr1 !== 32'h100) begin
            n_bad++;
            $display("FAIL reset_base: waddr=%h want 00000100", waddr1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        img = '{32'h3401_0005, 32'h0000_0000};
        send_image(1'b0);
        check_last_word("b2b");
    endtask

    task automatic test_gaps();
        pulse_start();
        img = '{32'h3401_0005, 32'h0000_0000};
        send_image(1'b1);
        check_last_word("gaps");
    endtask

    task automatic test_zero_count();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        n_cmp++;
        if (done0 !== 1'b1 || we0 !== 1'b0 || inReady0 !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_done: done=%b we=%b rdy=%b want 1 0 0", done0, we0, inReady0);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (holdCpu0 !== 1'b0 || done0 !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_hold: hold=%b done=%b want 0 1", holdCpu0, done0);
        end
    endtask

    task automatic test_overflow();
        pulse_start();
        send_byte(8'h04, 1'b0);
        send_byte(8'h01, 1'b0);
        repeat (2) begin
            n_cmp++;
            if (err0 !== 1'b1 || inReady0 !== 1'b0 || holdCpu0 !== 1'b1 || we0 !== 1'b0 ||
                done0 !== 1'b0) begin
                n_bad++;
                $display("FAIL ovf_err: err=%b rdy=%b hold=%b we=%b done=%b want 1 0 1 0 0",
                         err0, inReady0, holdCpu0, we0, done0);
            end
            @(posedge clk); #1;
        end
        pulse_start();
        // Limit case: exactly MAX_WORDS is legal, so the loader must be in DATA.
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        n_cmp++;
        if (err0 !== 1'b0 || inReady0 !== 1'b1) begin
            n_bad++;
            $display("FAIL max_legal: err=%b rdy=%b want 0 1", err0, inReady0);
        end
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_base_addr();
        img = '{32'h1234_5678};
        send_image(1'b0);
        check_last_word("base_first");
        n_cmp++;
        if (done1 !== 1'b1) begin
            n_bad++;
            $display("FAIL base_done_hi: done=%b want 1", done1);
        end
        pulse_start();
        n_cmp++;
        if (done1 !== 1'b0) begin
            n_bad++;
            $display("FAIL base_done_lo: done=%b want 0", done1);
        end
        img = '{32'hDEAD_BEEF};
        send_image(1'b0);
        check_last_word("base_second");
        n_cmp++;
        if (done1 !== 1'b1 || wdata1 !== 32'hDEAD_BEEF || waddr1 !== 32'h100) begin
            n_bad++;
            $display("FAIL base_final: done=%b addr=%h data=%h want 1 00000100 deadbeef",
                     done1, waddr1, wdata1);
        end
    endtask

    task automatic test_mid_reset();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (inReady0 !== 1'b1 || holdCpu0 !== 1'b1 || we0 !== 1'b0 || done0 !== 1'b0 ||
            err0 !== 1'b0 || waddr0 !== 32'h0 || wdata0 !== 32'h0 || waddr1 !== 32'h100 ||
            wdata1 !== 32'h0) begin
            n_bad++;
            $display("FAIL midrst_vals: rdy=%b hold=%b we=%b done=%b err=%b a0=%h d0=%h a1=%h d1=%h",
                     inReady0, holdCpu0, we0, done0, err0, waddr0, wdata0, waddr1, wdata1);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        img = '{32'h0102_0304, 32'hA5C3_0FF0, 32'h8000_0001};
        send_image(1'b0);
        check_last_word("midrst_reload");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_zero_count();
        test_overflow();
        test_base_addr();
        test_mid_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain: pending writes %0d/%0d want 0/0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time writer for the instruction memory: receives a byte stream over a valid/ready handshake and writes 32-bit instruction words into the instruction-memory write port. It holds the CPU in reset until the image is complete. It sits in the SOC between an external byte source (UART receiver or test host) and the instruction memory, and is the write-side counterpart of the CPU's read-only fetch path (ce/addr/data).

## Interface
Parameters:
- ADDR_WIDTH, default `PC_LENGTH (32): width of the write address; byte address.
- DATA_WIDTH, default `INST_LENGTH (32): width of the write data; fixed at 32 for 4-byte packing.
- BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
- MAX_WORDS, default 1024: instruction memory capacity in words.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous active-low reset.
- inData, input, 8: stream byte.
- inValid, input, 1: inData is valid.
- inReady, output, 1: loader accepts a byte this cycle.
- start, input, 1: one-cycle pulse; re-arms loading from DONE or ERR.
- we, output, 1: instruction-memory write enable, one-cycle pulse per word.
- waddr, output, ADDR_WIDTH: write byte address.
- wdata, output, DATA_WIDTH: write word.
- holdCpu, output, 1: high holds the CPU in reset.
- done, output, 1: image fully written (level).
- err, output, 1: header word count exceeds MAX_WORDS (level).

## Operation
- Stream format: 2-byte word count N (big-endian), then N words of 4 bytes each, big-endian. The first byte of a word goes to wdata[31:24].
- A byte is accepted when inValid && inReady. inReady = 1 in HDR0, HDR1 and DATA; 0 in DONE and ERR.
- States:
  - HDR0: accepted byte goes to cnt[15:8]; go to HDR1.
  - HDR1: accepted byte goes to cnt[7:0]. If N==0, go to DONE. If N>MAX_WORDS, go to ERR. Otherwise go to DATA, with the byte index at 0 and the word index at 0.
  - DATA: shift each accepted byte into the packing register. On the 4th byte, register wdata, waddr = BASE_ADDR + 4*wordIdx, and we=1. If this was word N-1, go to DONE; else increment wordIdx and stay in DATA.
  - DONE: done=1. start goes to HDR0 and clears done.
  - ERR: err=1, no writes. start goes to HDR0 and clears err.
- start is ignored in HDR0/HDR1/DATA.
- holdCpu = (state not in {DONE}) || we.
  - It stays high in ERR.
- waddr arithmetic is modulo 2^ADDR_WIDTH.
  - No wrap occurs within a legal image, because N ≤ MAX_WORDS.

## Timing
- Reset values:
  - state HDR0, inReady=1, holdCpu=1.
  - we=0, waddr=BASE_ADDR, wdata=0.
  - done=0, err=0.
  - Byte and word indices 0.
- Write latency: we is high exactly the cycle after the 4th byte of a word is accepted. The loader never stalls for a write, so inReady stays 1 throughout DATA.
- Back-to-back bytes with inValid held high give one word every 4 cycles. Gaps in inValid only delay packing.
- Last word: DONE is entered on the same edge that raises we. done=1 and we=1 in that cycle; holdCpu falls in the following cycle.
- Header N==0: DONE the cycle after the second header byte; we never asserted.
- Header N>MAX_WORDS: ERR the cycle after the second header byte; no we.
- start in DONE/ERR: HDR0 next cycle; inReady=1 and holdCpu=1 in that cycle.
- Reset mid-operation (any state, any byte index): immediate return to reset values.
  - A partially packed word is discarded.
  - Words already written are not undone.

## Structure
- The shared define file gains the state encodings `LOADER_HDR0, `LOADER_HDR1, `LOADER_DATA, `LOADER_DONE and `LOADER_ERR (3 bits), next to the existing `PC_LENGTH/`INST_LENGTH.
- Single module; the FSM, counters and 32-bit shift register are inline. No sub-module is warranted.
- The SOC wires holdCpu into the CPU reset and we/waddr/wdata into the instruction memory write port.

## Test plan
- Reset, then stream 00 02 34 01 00 05 00 00 00 00 with inValid held high. Required: we at waddr 0 with 0x34010005, then we at waddr 4 with 0x00000000; done=1; holdCpu=0 the cycle after the last we.
- Same stream with inValid low on alternate cycles. Required: identical writes, delayed; inReady stays 1 until DONE.
- Header 00 00. Required: DONE one cycle after the second byte, no we, holdCpu=0 the next cycle.
- Header 04 01 with MAX_WORDS=1024. Required: err=1, inReady=0, holdCpu=1, no we. A start pulse then returns to HDR0 with err=0.
- Assert rst after 2 data bytes of word 0. Required: all outputs at reset values, no we. A following full image loads correctly from waddr 0.
- BASE_ADDR=0x100, completed image, then start and a second 1-word image DEADBEEF. Required: we at waddr 0x100 with 0xDEADBEEF; done toggles 1→0→1.
